// File: rtl/uart_rx_fifo_byte_fifo.sv
// Byte FIFO with an inline register array, wrapping pointers and an occupancy count.
// A push into a full FIFO is accepted only when a pop frees the head slot in the same cycle.
module byte_fifo #(
    parameter int DEPTH    = 16,
    parameter int PTR_BITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  logic [7:0]          push_data,
    input  logic                pop,
    output logic [7:0]          rd_data,
    output logic [PTR_BITS:0]   count,
    output logic                empty,
    output logic                full
);

    localparam logic [PTR_BITS:0] DEPTH_CNT = DEPTH[PTR_BITS:0];

    logic [7:0]          mem [DEPTH];
    logic [PTR_BITS-1:0] rd_ptr;
    logic [PTR_BITS-1:0] wr_ptr;
    logic                pop_ok;
    logic                push_ok;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_CNT);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rd_data = mem[rd_ptr];

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Drains the uart rx holding register into a byte FIFO via the rx_ready/rx_ready_clear
// handshake; tracks a sticky overflow flag for bytes dropped while full.
module uart_rx_fifo #(
    parameter int DEPTH    = 16,
    parameter int PTR_BITS = 4
) (
    input  logic                raw_clk,
    input  logic                reset,
    input  logic [7:0]          uart_rx_data,
    input  logic                uart_rx_ready,
    output logic                uart_rx_ready_clear,
    input  logic                pop,
    output logic [7:0]          rd_data,
    output logic [PTR_BITS:0]   count,
    output logic                empty,
    output logic                full,
    output logic                overflow,
    input  logic                overflow_clear
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   capture;
    logic   drop;

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // WAIT holds off a second capture until the uart has dropped rx_ready.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (uart_rx_ready) begin
                    capture = 1'b1;
                    state_d = ACK;
                end
            end
            ACK:     state_d = WAIT;
            WAIT:    state_d = uart_rx_ready ? WAIT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign uart_rx_ready_clear = (state_q == ACK);

    // A pop in the capture cycle frees a slot, so only full-without-pop drops.
    assign drop = capture && full && !pop;

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (overflow_clear) begin
            overflow <= 1'b0;
        end
    end

    byte_fifo #(
        .DEPTH    (DEPTH),
        .PTR_BITS (PTR_BITS)
    ) u_fifo (
        .clk       (raw_clk),
        .reset     (reset),
        .push      (capture),
        .push_data (uart_rx_data),
        .pop       (pop),
        .rd_data   (rd_data),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: table-driven fill/overflow/drain plus hand sequences.
module tb_uart_rx_fifo;

    logic       raw_clk = 1'b0;
    logic       reset;
    logic [7:0] uart_rx_data;
    logic       uart_rx_ready;
    logic       uart_rx_ready_clear;
    logic       pop;
    logic [7:0] rd_data;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       overflow_clear;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    uart_rx_fifo #(.DEPTH(16), .PTR_BITS(4)) dut (
        .raw_clk             (raw_clk),
        .reset               (reset),
        .uart_rx_data        (uart_rx_data),
        .uart_rx_ready       (uart_rx_ready),
        .uart_rx_ready_clear (uart_rx_ready_clear),
        .pop                 (pop),
        .rd_data             (rd_data),
        .count               (count),
        .empty               (empty),
        .full                (full),
        .overflow            (overflow),
        .overflow_clear      (overflow_clear)
    );

    always #5 raw_clk = ~raw_clk;

    typedef struct {
        int         op;        // 0 send, 1 pop, 2 overflow_clear
        logic [7:0] data;
        bit         with_pop;
        bit         accept;
        int         exp_count;
        bit         exp_full;
        bit         exp_empty;
        bit         exp_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge raw_clk);
        reset = 1'b1;
        @(negedge raw_clk);
        reset = 1'b0;
        exp_q.delete();
    endtask

    // Starts and ends at a negedge with the capture FSM in IDLE.
    task automatic send_byte(input logic [7:0] b, input bit with_pop, input bit accept,
                             input bit with_clr);
        @(negedge raw_clk);
        uart_rx_data   = b;
        uart_rx_ready  = 1'b1;
        pop            = with_pop;
        overflow_clear = with_clr;
        if (with_pop) begin
            if (exp_q.size() == 0) check("sb_underflow", 1, 0);
            else check("rd_data_pop_in_capture", int'(rd_data), int'(exp_q.pop_front()));
        end
        @(posedge raw_clk);
        #1;
        pop            = 1'b0;
        overflow_clear = 1'b0;
        check("ack_pulse", int'(uart_rx_ready_clear), 1);
        if (accept) exp_q.push_back(b);
        @(negedge raw_clk);
        uart_rx_ready = 1'b0;
        repeat (2) @(negedge raw_clk);
    endtask

    task automatic pop_one();
        @(negedge raw_clk);
        if (exp_q.size() == 0) check("sb_underflow", 1, 0);
        else check("rd_data", int'(rd_data), int'(exp_q.pop_front()));
        pop = 1'b1;
        @(negedge raw_clk);
        pop = 1'b0;
    endtask

    task automatic clear_ovf();
        @(negedge raw_clk);
        overflow_clear = 1'b1;
        @(negedge raw_clk);
        overflow_clear = 1'b0;
    endtask

    initial begin
        int pulses;
        int max_cnt;
        vec_t v;

        for (int i = 0; i < 16; i++) begin
            v = '{0, 8'(8'h10 + i), 1'b0, 1'b1, i + 1, (i == 15), 1'b0, 1'b0};
            vecs.push_back(v);
        end
        v = '{0, 8'h99, 1'b0, 1'b0, 16, 1'b1, 1'b0, 1'b1}; vecs.push_back(v);
        v = '{2, 8'h00, 1'b0, 1'b0, 16, 1'b1, 1'b0, 1'b0}; vecs.push_back(v);
        v = '{0, 8'h55, 1'b1, 1'b1, 16, 1'b1, 1'b0, 1'b0}; vecs.push_back(v);
        for (int i = 0; i < 16; i++) begin
            v = '{1, 8'h00, 1'b0, 1'b0, 15 - i, 1'b0, (i == 15), 1'b0};
            vecs.push_back(v);
        end

        reset = 1'b1; uart_rx_data = '0; uart_rx_ready = 1'b0;
        pop = 1'b0; overflow_clear = 1'b0;
        repeat (2) @(negedge raw_clk);
        reset = 1'b0;
        #1;
        check("reset_count", int'(count), 0);
        check("reset_empty", int'(empty), 1);
        check("reset_full", int'(full), 0);
        check("reset_ovf", int'(overflow), 0);
        check("reset_clear", int'(uart_rx_ready_clear), 0);

        // Long rx_ready assertion gives exactly one capture.
        @(negedge raw_clk);
        uart_rx_data = 8'h41; uart_rx_ready = 1'b1;
        pulses = 0;
        repeat (4) begin @(posedge raw_clk); #1; pulses += int'(uart_rx_ready_clear); end
        @(negedge raw_clk);
        uart_rx_ready = 1'b0;
        repeat (3) begin @(posedge raw_clk); #1; pulses += int'(uart_rx_ready_clear); end
        check("single_pulse", pulses, 1);
        check("t1_count", int'(count), 1);
        check("t1_rd_data", int'(rd_data), 8'h41);
        check("t1_empty", int'(empty), 0);
        do_reset();

        foreach (vecs[i]) begin
            case (vecs[i].op)
                0: send_byte(vecs[i].data, vecs[i].with_pop, vecs[i].accept, 1'b0);
                1: pop_one();
                default: clear_ovf();
            endcase
            #1;
            check($sformatf("vec%0d_count", i), int'(count), vecs[i].exp_count);
            check($sformatf("vec%0d_full", i), int'(full), int'(vecs[i].exp_full));
            check($sformatf("vec%0d_empty", i), int'(empty), int'(vecs[i].exp_empty));
            check($sformatf("vec%0d_ovf", i), int'(overflow), int'(vecs[i].exp_ovf));
        end
        check("sb_drained", exp_q.size(), 0);

        // Alternating push/pop wraps the pointers twice.
        max_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            send_byte(8'(i), 1'b0, 1'b1, 1'b0);
            #1;
            if (int'(count) > max_cnt) max_cnt = int'(count);
            check("alt_empty_after_push", int'(empty), 0);
            pop_one();
            #1;
            check("alt_empty_after_pop", int'(empty), 1);
        end
        check("alt_max_count", max_cnt, 1);

        // Pop while empty is ignored.
        @(negedge raw_clk);
        pop = 1'b1;
        @(negedge raw_clk);
        pop = 1'b0;
        #1;
        check("empty_pop_count", int'(count), 0);
        check("empty_pop_empty", int'(empty), 1);

        // Fill, then a drop coinciding with overflow_clear leaves overflow set.
        for (int i = 0; i < 16; i++) send_byte(8'(8'hA0 + i), 1'b0, 1'b1, 1'b0);
        send_byte(8'hEE, 1'b0, 1'b0, 1'b1);
        #1;
        check("drop_vs_clear_ovf", int'(overflow), 1);
        check("drop_count", int'(count), 16);

        // Drain to five entries, then reset while the FSM is in ACK.
        for (int i = 0; i < 11; i++) pop_one();
        #1;
        check("five_count", int'(count), 5);
        @(negedge raw_clk);
        uart_rx_data = 8'h77; uart_rx_ready = 1'b1;
        @(posedge raw_clk);
        #1;
        check("in_ack_clear", int'(uart_rx_ready_clear), 1);
        @(negedge raw_clk);
        reset = 1'b1;
        @(posedge raw_clk);
        #1;
        check("ack_reset_count", int'(count), 0);
        check("ack_reset_empty", int'(empty), 1);
        check("ack_reset_ovf", int'(overflow), 0);
        check("ack_reset_clear", int'(uart_rx_ready_clear), 0);
        exp_q.delete();
        @(negedge raw_clk);
        reset = 1'b0;
        @(posedge raw_clk);
        #1;
        check("recapture_ack", int'(uart_rx_ready_clear), 1);
        @(negedge raw_clk);
        uart_rx_ready = 1'b0;
        repeat (2) @(negedge raw_clk);
        #1;
        check("recapture_count", int'(count), 1);
        check("recapture_data", int'(rd_data), 8'h77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
